// File: rtl/sobel_pkg.sv
`default_nettype none
// ==========================================================================
// sobel_pkg : shared widths and types for the Sobel pixel datapath
// Rev 1.0
// ==========================================================================
package sobel_pkg;

    localparam int PIXEL_W = 24;
    localparam int WORD_W  = 32;
    localparam int NUM_PIX = 4;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2
    } word_idx_t;

endpackage : sobel_pkg
`default_nettype wire

// File: rtl/pre_gray_scale_if.sv
`default_nettype none
// ==========================================================================
// pre_gray_scale_if : word stream in, four parallel pixels out
// Rev 1.0
// ==========================================================================
interface pre_gray_scale_if;
    import sobel_pkg::*;

    logic [WORD_W-1:0]         read_word;
    logic                      start_en;
    logic                      store_en;
    pixel_t [NUM_PIX-1:0]      out_pixels;
    logic                      gray_en;

    modport master (
        output read_word, start_en, store_en,
        input  out_pixels, gray_en
    );

    modport slave (
        input  read_word, start_en, store_en,
        output out_pixels, gray_en
    );

endinterface : pre_gray_scale_if
`default_nettype wire

// File: rtl/pre_gray_scale.sv
`default_nettype none
// ==========================================================================
// pre_gray_scale : repacks three 32-bit words into four 24-bit RGB pixels
// Rev 1.0
// ==========================================================================
module pre_gray_scale
    import sobel_pkg::*;
(
    input  wire               clk,
    input  wire               n_rst,
    pre_gray_scale_if.slave   bus
);

    word_idx_t              widx_q, widx_d;
    logic [15:0]            hold_q, hold_d;
    pixel_t [NUM_PIX-1:0]   pix_q,  pix_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            widx_q <= W0;
            hold_q <= '0;
            pix_q  <= '0;
        end else begin
            widx_q <= widx_d;
            hold_q <= hold_d;
            pix_q  <= pix_d;
        end
    end

    always_comb begin
        widx_d = widx_q;
        hold_d = hold_q;
        pix_d  = pix_q;
        if (bus.start_en) begin
            // start wins over a coincident store; the word is dropped
            widx_d = W0;
            hold_d = '0;
            pix_d  = '0;
        end else if (bus.store_en) begin
            case (widx_q)
                W0: begin
                    pix_d[3]    = bus.read_word[31:8];
                    hold_d[7:0] = bus.read_word[7:0];
                    widx_d      = W1;
                end
                W1: begin
                    pix_d[2] = {hold_q[7:0], bus.read_word[31:16]};
                    hold_d   = bus.read_word[15:0];
                    widx_d   = W2;
                end
                W2: begin
                    pix_d[1] = {hold_q, bus.read_word[31:24]};
                    pix_d[0] = bus.read_word[23:0];
                    widx_d   = W0;
                end
                default: widx_d = W0;
            endcase
        end
    end

    assign bus.out_pixels = pix_q;
    assign bus.gray_en    = bus.store_en & ~bus.start_en & (widx_q == W2);

endmodule : pre_gray_scale
`default_nettype wire

// File: tb/tb_pre_gray_scale.sv
`default_nettype none
// ==========================================================================
// tb_pre_gray_scale : directed self-checking bench for pre_gray_scale
// Rev 1.0
// ==========================================================================
module tb_pre_gray_scale;
    import sobel_pkg::*;

    logic clk;
    logic n_rst;
    int   tests_run;
    int   tests_failed;

    pre_gray_scale_if bus ();

    pre_gray_scale dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check gray_en before the edge and pixels after it.
    task automatic step(input string tag, input logic st, input logic sto,
                        input logic [31:0] word, input logic exp_gray,
                        input logic [95:0] exp_pix);
        @(negedge clk);
        bus.start_en  = st;
        bus.store_en  = sto;
        bus.read_word = word;
        #1;
        check({tag, "_gray"}, {95'd0, bus.gray_en}, {95'd0, exp_gray});
        @(posedge clk);
        #1;
        check({tag, "_pix"}, bus.out_pixels, exp_pix);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        n_rst         = 1'b0;
        bus.start_en  = 1'b0;
        bus.store_en  = 1'b0;
        bus.read_word = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix",  bus.out_pixels, 96'd0);
        check("reset_gray", {95'd0, bus.gray_en}, 96'd0);
        @(negedge clk);
        n_rst = 1'b1;

        step("start0", 1, 0, 32'h0,        0, 96'd0);
        step("w0",     0, 1, 32'hFF00AAF0, 0, {24'hFF00AA, 24'h0, 24'h0, 24'h0});
        step("w1",     0, 1, 32'h1300AA87, 0, {24'hFF00AA, 24'hF01300, 24'h0, 24'h0});
        step("w2",     0, 1, 32'h1300AA87, 1, {24'hFF00AA, 24'hF01300, 24'hAA8713, 24'h00AA87});
        step("idle",   0, 0, 32'hFFFFFFFF, 0, {24'hFF00AA, 24'hF01300, 24'hAA8713, 24'h00AA87});

        // start together with store mid-group
        step("mid_w0", 0, 1, 32'h11223344, 0, {24'h112233, 24'hF01300, 24'hAA8713, 24'h00AA87});
        step("both",   1, 1, 32'hDEADBEEF, 0, 96'd0);
        step("post_w0",0, 1, 32'h55667788, 0, {24'h556677, 24'h0, 24'h0, 24'h0});

        // async reset mid-group discards the partial group
        @(negedge clk);
        bus.store_en = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_pix", bus.out_pixels, 96'd0);
        @(negedge clk);
        n_rst = 1'b1;
        step("rst_w0", 0, 1, 32'hCAFEBABE, 0, {24'hCAFEBA, 24'h0, 24'h0, 24'h0});

        // two full groups back-to-back
        step("g_start", 1, 0, 32'h0,        0, 96'd0);
        step("s1",      0, 1, 32'h01020304, 0, {24'h010203, 24'h0, 24'h0, 24'h0});
        step("s2",      0, 1, 32'h05060708, 0, {24'h010203, 24'h040506, 24'h0, 24'h0});
        step("s3",      0, 1, 32'h090A0B0C, 1, {24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C});
        step("s4",      0, 1, 32'hA1A2A3A4, 0, {24'hA1A2A3, 24'h040506, 24'h070809, 24'h0A0B0C});
        step("s5",      0, 1, 32'hB1B2B3B4, 0, {24'hA1A2A3, 24'hA4B1B2, 24'h070809, 24'h0A0B0C});
        step("s6",      0, 1, 32'hC1C2C3C4, 1, {24'hA1A2A3, 24'hA4B1B2, 24'hB3B4C1, 24'hC2C3C4});
        step("end",     0, 0, 32'h0,        0, {24'hA1A2A3, 24'hA4B1B2, 24'hB3B4C1, 24'hC2C3C4});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pre_gray_scale
`default_nettype wire
